// File: rtl/sprite_blit_engine.sv
// Sprite blitter: copies a width/height-prefixed image from one of several
// ROMs into video memory with clipping and a transparent colour key. It can
// also erase a sprite footprint or clear the whole screen.
module sprite_blit_engine #(
  parameter int SCR_W  = 640,
  parameter int SCR_H  = 480,
  parameter int PIX_W  = 6,
  parameter int N_SRC  = 4,
  parameter int ROM_AW = 16,
  parameter logic [PIX_W-1:0] TRANSP = 6'h24,
  parameter logic [PIX_W-1:0] BG     = '0,
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int AW = $clog2(SCR_W * SCR_H),
  localparam int XW = $clog2(SCR_W) + 1,
  localparam int YW = $clog2(SCR_H) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_vld,
  output logic                     cmd_rdy,
  input  logic [1:0]               cmd_op,
  input  logic [SW-1:0]            cmd_src,
  input  logic signed [XW-1:0]     cmd_x,
  input  logic signed [YW-1:0]     cmd_y,
  output logic [SW-1:0]            rom_sel,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [PIX_W-1:0]         rom_data,
  output logic [AW-1:0]            waddr,
  output logic [PIX_W-1:0]         wdata,
  output logic                     we,
  output logic                     busy,
  output logic                     done
);

  localparam int DW   = 2 * PIX_W;
  localparam int CW   = (XW > YW) ? XW : YW;
  localparam int SXW  = ((CW > DW) ? CW : DW) + 2;
  localparam int NPIX = SCR_W * SCR_H;
  localparam logic [AW-1:0]         LAST_A = AW'(NPIX - 1);
  localparam logic signed [SXW-1:0] S_ZERO = '0;
  localparam logic signed [SXW-1:0] X_LIM  = SXW'(SCR_W);
  localparam logic signed [SXW-1:0] Y_LIM  = SXW'(SCR_H);

  typedef enum logic [2:0] {CLR, IDLE, HDR, DRAW, FIN} state_t;

  state_t state_q, state_d;

  // control registers
  logic                  rst_q;
  logic [AW-1:0]         clr_a_q;
  logic [2:0]            hc_q;
  logic                  pend_q;
  logic                  vld_p1;

  // datapath registers
  logic [1:0]            op_q;
  logic [SW-1:0]         src_q;
  logic signed [XW-1:0]  x_q;
  logic signed [YW-1:0]  y_q;
  logic [PIX_W-1:0]      w_hi_q, w_lo_q, h_hi_q, h_lo_q;
  logic [DW-1:0]         c_q, r_q;
  logic signed [SXW-1:0] sx_p0, sy_p0;
  logic [ROM_AW-1:0]     ptr_q;
  logic [AW-1:0]         waddr_p1;

  logic [DW-1:0]         img_w, img_h, h_now, w_m1, h_m1;
  logic                  hdr_last, pix_last, inb_p0;
  logic [AW-1:0]         lin_p0;

  assign img_w    = {w_hi_q, w_lo_q};
  assign img_h    = {h_hi_q, h_lo_q};
  assign h_now    = {h_hi_q, rom_data};
  assign w_m1     = img_w - DW'(1);
  assign h_m1     = img_h - DW'(1);
  assign hdr_last = (state_q == HDR) && (hc_q == 3'd4);
  assign pix_last = (c_q == w_m1) && (r_q == h_m1);
  assign inb_p0   = (sx_p0 >= S_ZERO) && (sx_p0 < X_LIM) &&
                    (sy_p0 >= S_ZERO) && (sy_p0 < Y_LIM);
  assign lin_p0   = AW'(sy_p0) * AW'(SCR_W) + AW'(sx_p0);
  assign rom_sel  = src_q;

  // State register; reset aborts anything in flight and restarts the clear
  always_ff @(posedge clk) begin
    if (rst) state_q <= CLR;
    else     state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    cmd_rdy  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    we       = 1'b0;
    wdata    = rom_data;
    waddr    = waddr_p1;
    rom_addr = '0;
    case (state_q)
      CLR: begin
        // the cycle right after reset is silent so the clear starts cleanly at 0
        we    = !rst_q;
        wdata = BG;
        waddr = clr_a_q;
        if (!rst_q && clr_a_q == LAST_A) state_d = FIN;
      end
      IDLE: begin
        busy    = 1'b0;
        cmd_rdy = 1'b1;
        if (cmd_vld) begin
          case (cmd_op)
            2'b10:   state_d = CLR;
            2'b11:   state_d = FIN;
            default: state_d = HDR;
          endcase
        end
      end
      HDR: begin
        if (hc_q < 3'd4) rom_addr = ROM_AW'(hc_q);
        if (hc_q == 3'd4) begin
          if (img_w == '0 || h_now == '0) state_d = FIN;
          else                            state_d = DRAW;
        end
      end
      DRAW: begin
        if (pend_q) rom_addr = ptr_q;
        else        state_d  = FIN;
        // write stage: ROM word for the previous address is on rom_data now
        if (vld_p1 && rom_data != TRANSP) begin
          we    = 1'b1;
          wdata = op_q[0] ? BG : rom_data;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = CLR;
    endcase
  end

  // Control: header counter, clear address, pixel-pending and write-valid
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      clr_a_q <= '0;
      hc_q    <= '0;
      pend_q  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      if (state_q == IDLE)             clr_a_q <= '0;
      else if (state_q == CLR && we)   clr_a_q <= clr_a_q + AW'(1);
      hc_q <= (state_q == HDR) ? hc_q + 3'd1 : 3'd0;
      if (hdr_last)                                 pend_q <= 1'b1;
      else if (state_q == DRAW && pend_q && pix_last) pend_q <= 1'b0;
      vld_p1 <= (state_q == DRAW) && pend_q && inb_p0;
    end
  end

  // Datapath: command latch, header capture, pixel walk (p0 -> p1)
  always_ff @(posedge clk) begin
    if (state_q == IDLE && cmd_vld) begin
      op_q  <= cmd_op;
      src_q <= cmd_src;
      x_q   <= cmd_x;
      y_q   <= cmd_y;
    end
    if (state_q == HDR) begin
      case (hc_q)
        3'd1:    w_hi_q <= rom_data;
        3'd2:    w_lo_q <= rom_data;
        3'd3:    h_hi_q <= rom_data;
        3'd4:    h_lo_q <= rom_data;
        default: ;
      endcase
    end
    if (hdr_last) begin
      c_q   <= '0;
      r_q   <= '0;
      sx_p0 <= SXW'(x_q);
      sy_p0 <= SXW'(y_q);
      ptr_q <= ROM_AW'(4);
    end else if (state_q == DRAW && pend_q) begin
      // --- p0 -> p1: screen address of the pixel whose ROM word is in flight
      waddr_p1 <= lin_p0;
      ptr_q    <= ptr_q + ROM_AW'(1);
      if (c_q == w_m1) begin
        c_q   <= '0;
        sx_p0 <= SXW'(x_q);
        r_q   <= r_q + DW'(1);
        sy_p0 <= sy_p0 + SXW'(1);
      end else begin
        c_q   <= c_q + DW'(1);
        sx_p0 <= sx_p0 + SXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Bench for sprite_blit_engine on a reduced 16x8 screen: a command table is
// applied in a loop, expected video writes come from a small reference model
// into a queue, and a monitor pops and compares every write.
module tb_sprite_blit_engine;

  localparam int SW_  = 16;
  localparam int SH_  = 8;
  localparam int NP   = SW_ * SH_;
  localparam int XW   = 5;
  localparam int YW   = 4;
  localparam int AW   = 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_vld = 1'b0;
  logic                 cmd_rdy;
  logic [1:0]           cmd_op = 2'b11;
  logic [1:0]           cmd_src = '0;
  logic signed [XW-1:0] cmd_x = '0;
  logic signed [YW-1:0] cmd_y = '0;
  logic [1:0]           rom_sel;
  logic [15:0]          rom_addr;
  logic [5:0]           rom_data;
  logic [AW-1:0]        waddr;
  logic [5:0]           wdata;
  logic                 we, busy, done;

  sprite_blit_engine #(.SCR_W(SW_), .SCR_H(SH_)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .waddr(waddr), .wdata(wdata), .we(we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [5:0] rom [0:3][0:63];
  always @(posedge clk) rom_data <= rom[rom_sel][rom_addr[5:0]];

  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // every video write is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (mon_en && we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d required none", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(waddr) != e.a || int'(wdata) != e.d) begin
          errors++;
          $display("FAIL write: got addr %0d data %0d required addr %0d data %0d",
                   waddr, wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic push_clear();
    for (int i = 0; i < NP; i++) exp_q.push_back('{i, 0});
  endtask

  task automatic push_expect(input int op, input int src, input int x, input int y);
    int w, h, px, sx, sy;
    if (op == 3) return;
    if (op == 2) begin push_clear(); return; end
    w = int'(rom[src][0]) * 64 + int'(rom[src][1]);
    h = int'(rom[src][2]) * 64 + int'(rom[src][3]);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        px = int'(rom[src][4 + r * w + c]);
        sx = x + c;
        sy = y + r;
        if (sx >= 0 && sx < SW_ && sy >= 0 && sy < SH_ && px != 6'h24)
          exp_q.push_back('{sy * SW_ + sx, (op == 1) ? 0 : px});
      end
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s_timeout: got no done required done", name);
    end
  endtask

  task automatic run_cmd(input int op, input int src, input int x, input int y,
                         input int hold, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 500) begin @(negedge clk); n++; end
    chk("cmd_rdy_before", int'(cmd_rdy), 1);
    cmd_op = 2'(op); cmd_src = 2'(src); cmd_x = XW'(x); cmd_y = YW'(y);
    cmd_vld = 1'b1;
    push_expect(op, src, x, y);
    n = 0;
    while (n < 1000) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n >= hold) cmd_vld = 1'b0;
      if (done) break;
    end
    cmd_vld = 1'b0;
    chk("done_latency", n, lat);
    chk("writes_left", exp_q.size(), 0);
    @(negedge clk);
    chk("cmd_rdy_after", int'(cmd_rdy), 1);
  endtask

  typedef struct { int op; int src; int x; int y; int hold; int lat; } vec_t;
  vec_t vecs[$];

  initial begin
    int n;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 64; a++) rom[s][a] = '0;
    rom[0][3] = 6'd3;                                   // W=0, H=3
    rom[1][1] = 6'd2; rom[1][3] = 6'd2;                 // 2x2
    rom[1][4] = 6'd1; rom[1][5] = 6'd2; rom[1][6] = 6'h24; rom[1][7] = 6'd3;
    rom[2][1] = 6'd3; rom[2][3] = 6'd2;                 // 3x2
    rom[2][4] = 6'd5; rom[2][5] = 6'd6; rom[2][6] = 6'h24;
    rom[2][7] = 6'd8; rom[2][8] = 6'd9; rom[2][9] = 6'd10;
    rom[3][1] = 6'd1;                                   // W=1, H=0

    //          op src  x   y  hold lat
    vecs.push_back('{0, 1, 10,  5, 1, 11});
    vecs.push_back('{0, 1, -1,  7, 1, 11});
    vecs.push_back('{1, 1, 10,  5, 1, 11});
    vecs.push_back('{0, 0,  3,  3, 1,  6});
    vecs.push_back('{0, 3,  3,  3, 1,  6});
    vecs.push_back('{3, 0,  0,  0, 1,  1});
    vecs.push_back('{0, 2, 14, -1, 1, 13});
    vecs.push_back('{0, 1, 15,  0, 1, 11});
    vecs.push_back('{0, 2,  3,  2, 9, 13});
    vecs.push_back('{2, 0,  0,  0, 1, 129});

    // reset for two cycles, then the full clear
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", int'(we), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cmd_rdy", int'(cmd_rdy), 0);
    chk("rst_done", int'(done), 0);
    push_clear();
    mon_en = 1'b1;
    rst = 1'b0;
    wait_done("clear", n);
    chk("clear_writes_left", exp_q.size(), 0);
    @(negedge clk);
    chk("clear_cmd_rdy", int'(cmd_rdy), 1);

    foreach (vecs[i])
      run_cmd(vecs[i].op, vecs[i].src, vecs[i].x, vecs[i].y, vecs[i].hold, vecs[i].lat);

    // reset in the middle of a draw aborts it and restarts the clear at 0
    mon_en = 1'b0;
    @(negedge clk);
    cmd_op = 2'b00; cmd_src = 2'd2; cmd_x = '0; cmd_y = '0; cmd_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_draw_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_we", int'(we), 0);
    chk("abort_waddr", int'(waddr), 0);
    chk("abort_cmd_rdy", int'(cmd_rdy), 0);
    exp_q.delete();
    push_clear();
    rst = 1'b0;
    mon_en = 1'b1;
    wait_done("reclear", n);
    chk("reclear_writes_left", exp_q.size(), 0);

    run_cmd(0, 1, 10, 5, 1, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
